// File: rtl/deu_wb_arb_pkg.sv
// deu_wb_arb_pkg: shared widths and types for the writeback arbiter.
//   LA64_ARF_SEL    - architectural register select width
//   LA64_DATA_WIDTH - register data width
//   WB_NPORTS       - register file write ports (fixed at 3)
//   wb_entry_t      - buffered writeback result {addr, data}
package deu_wb_arb_pkg;

  localparam int LA64_ARF_SEL    = 5;
  localparam int LA64_DATA_WIDTH = 64;
  localparam int WB_NPORTS       = 3;

  typedef struct packed {
    logic [LA64_ARF_SEL-1:0]    addr;
    logic [LA64_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/deu_wb_arb_fifo.sv
// deu_wb_fifo: per-source synchronous result FIFO with registered full/empty.
//   clk, rst_n - clock, async active-low reset
//   push       - write push_entry (ignored while full)
//   pop        - drop head (ignored while empty)
//   head       - current head entry, valid when !empty
//   full/empty - registered status
module deu_wb_fifo
  import deu_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic        do_push, do_pop;
  wb_entry_t   mem [DEPTH];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wptr_n  = wptr + (AW+1)'(do_push);
  assign rptr_n  = rptr + (AW+1)'(do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= push_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= (wptr_n - rptr_n) == (AW+1)'(DEPTH);
      empty <= wptr_n == rptr_n;
    end
  end
endmodule

// File: rtl/deu_wb_dff.sv
// deu_wb_dff / deu_wb_dffe: async active-low reset flops (reset to zero),
// the latter with a load enable.
//   clk, rst_n - clock, async active-low reset
//   en         - load enable (dffe only)
//   d / q      - data in / registered out
module deu_wb_dff #(
  parameter int W = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= d;
endmodule

module deu_wb_dffe #(
  parameter int W = 1
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/deu_wb_arb.sv
// deu_wb_arb: writeback arbiter in front of the 3-write-port GPR file.
// Buffers results from NSRC sources in per-source FIFOs, grants up to three
// FIFO heads per cycle in round-robin scan order, and never drives two write
// ports to the same register in one cycle.
//   src_valid/src_ready/src_addr/src_data - per-source result handshake
//   we0..2/waddr0..2/wd0..2               - registered register-file writes
//   waw_err                               - sticky same-cycle address conflict
//   idle                                  - FIFOs empty and no write on outputs
module deu_wb_arb
  import deu_wb_arb_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int FIFO_DEPTH = 2
)(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NSRC-1:0]                        src_valid,
  output logic [NSRC-1:0]                        src_ready,
  input  logic [NSRC-1:0][LA64_ARF_SEL-1:0]      src_addr,
  input  logic [NSRC-1:0][LA64_DATA_WIDTH-1:0]   src_data,
  output logic                                   we0,
  output logic                                   we1,
  output logic                                   we2,
  output logic [LA64_ARF_SEL-1:0]                waddr0,
  output logic [LA64_ARF_SEL-1:0]                waddr1,
  output logic [LA64_ARF_SEL-1:0]                waddr2,
  output logic [LA64_DATA_WIDTH-1:0]             wd0,
  output logic [LA64_DATA_WIDTH-1:0]             wd1,
  output logic [LA64_DATA_WIDTH-1:0]             wd2,
  output logic                                   waw_err,
  output logic                                   idle
);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CW = $clog2(WB_NPORTS + 1);

  logic [NSRC-1:0]       push, pop, full, empty;
  wb_entry_t             head [NSRC];
  logic [PW-1:0]         rr_ptr, rr_nxt;
  logic                  any_grant, conflict;
  logic [WB_NPORTS-1:0]  port_vld;
  wb_entry_t             port_ent [WB_NPORTS];

  logic [WB_NPORTS-1:0]                      we_q;
  logic [WB_NPORTS-1:0][LA64_ARF_SEL-1:0]    waddr_q;
  logic [WB_NPORTS-1:0][LA64_DATA_WIDTH-1:0] wd_q;

  // ready is the registered inverse of full, so a full FIFO never sees a push.
  assign src_ready = ~full;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wb_entry_t in_ent;
    assign in_ent  = '{addr: src_addr[i], data: src_data[i]};
    // r0 writes are accepted by the handshake but never stored.
    assign push[i] = src_valid[i] & ~full[i] & (|src_addr[i]);

    deu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push[i]),
      .push_entry (in_ent),
      .pop        (pop[i]),
      .head       (head[i]),
      .full       (full[i]),
      .empty      (empty[i])
    );
  end

  // Round-robin scan from rr_ptr; the k-th granted head lands on port k.
  // A head matching an address already granted this cycle waits a cycle.
  always_comb begin
    logic [CW-1:0] gcnt;
    logic [PW-1:0] idx, last;
    logic          hit;
    pop      = '0;
    conflict = 1'b0;
    port_vld = '0;
    gcnt     = '0;
    last     = rr_ptr;
    idx      = '0;
    hit      = 1'b0;
    for (int p = 0; p < WB_NPORTS; p++) port_ent[p] = '0;
    for (int j = 0; j < NSRC; j++) begin
      idx = PW'((int'(rr_ptr) + j) % NSRC);
      if (!empty[idx] && (int'(gcnt) < WB_NPORTS)) begin
        hit = 1'b0;
        for (int p = 0; p < WB_NPORTS; p++)
          if ((p < int'(gcnt)) && (port_ent[p].addr == head[idx].addr)) hit = 1'b1;
        if (hit) begin
          conflict = 1'b1;
        end else begin
          port_vld[gcnt] = 1'b1;
          port_ent[gcnt] = head[idx];
          pop[idx]       = 1'b1;
          last           = idx;
          gcnt           = gcnt + CW'(1);
        end
      end
    end
    any_grant = |port_vld;
    rr_nxt    = PW'((int'(last) + 1) % NSRC);
  end

  deu_wb_dffe #(.W(PW)) u_rr (
    .clk (clk), .rst_n (rst_n), .en (any_grant), .d (rr_nxt), .q (rr_ptr)
  );

  deu_wb_dff #(.W(1)) u_waw (
    .clk (clk), .rst_n (rst_n), .d (waw_err | conflict), .q (waw_err)
  );

  // Ungranted ports keep their last address/data; only we drops.
  for (genvar p = 0; p < WB_NPORTS; p++) begin : g_port
    deu_wb_dff #(.W(1)) u_we (
      .clk (clk), .rst_n (rst_n), .d (port_vld[p]), .q (we_q[p])
    );
    deu_wb_dffe #(.W(LA64_ARF_SEL)) u_addr (
      .clk (clk), .rst_n (rst_n), .en (port_vld[p]),
      .d (port_ent[p].addr), .q (waddr_q[p])
    );
    deu_wb_dffe #(.W(LA64_DATA_WIDTH)) u_data (
      .clk (clk), .rst_n (rst_n), .en (port_vld[p]),
      .d (port_ent[p].data), .q (wd_q[p])
    );
  end

  assign we0    = we_q[0];
  assign we1    = we_q[1];
  assign we2    = we_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wd0    = wd_q[0];
  assign wd1    = wd_q[1];
  assign wd2    = wd_q[2];

  assign idle = (&empty) & ~(|we_q);

endmodule

// File: tb/tb_deu_wb_arb.sv
// tb_deu_wb_arb: vector table for single-shot arbitration cases plus a
// scoreboard over streaming traffic (per-source order, no loss, no
// same-cycle address duplicates), reset and backpressure sequences.
module tb_deu_wb_arb;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       src_valid;
  logic [3:0]       src_ready;
  logic [3:0][4:0]  src_addr;
  logic [3:0][63:0] src_data;
  logic             we0, we1, we2;
  logic [4:0]       waddr0, waddr1, waddr2;
  logic [63:0]      wd0, wd1, wd2;
  logic             waw_err, idle;

  deu_wb_arb #(.NSRC(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .we0(we0), .we1(we1), .we2(we2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wd0(wd0), .wd1(wd1), .wd2(wd2),
    .waw_err(waw_err), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;
  bit r1_low = 1'b0;
  int acc [4];
  int seq [4];
  logic [68:0] exp_q [4][$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard: each write must be the oldest outstanding result of the
  // source encoded in data[63:60].
  task automatic mon();
    logic [2:0]  w;
    logic [4:0]  a [3];
    logic [63:0] d [3];
    logic        dup;
    int          s;
    logic [68:0] e;
    w = {we2, we1, we0};
    a[0] = waddr0; a[1] = waddr1; a[2] = waddr2;
    d[0] = wd0;    d[1] = wd1;    d[2] = wd2;
    if (|w) begin
      chk("sb_port_pack", 64'((w[1] & ~w[0]) | (w[2] & ~w[1])), 64'd0);
      dup = (w[0] & w[1] & (a[0] == a[1])) | (w[0] & w[2] & (a[0] == a[2])) |
            (w[1] & w[2] & (a[1] == a[2]));
      chk("sb_dup_addr", 64'(dup), 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      if (w[k]) begin
        s = int'(d[k][63:60]);
        if (s > 3 || exp_q[s].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected port=%0d addr=%0d data=%0h", k, a[k], d[k]);
        end else begin
          e = exp_q[s].pop_front();
          chk($sformatf("sb_addr_src%0d", s), 64'(a[k]), 64'(e[68:64]));
          chk($sformatf("sb_data_src%0d", s), d[k], e[63:0]);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_on && rst_n) mon();
  end

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One streaming cycle: source i uses registers i*8..i*8+7, so heads never
  // collide across sources; src0 occasionally hits r0 (dropped).
  task automatic stream_cycle(input logic [3:0] v);
    logic [4:0]  a;
    logic [63:0] dt;
    @(negedge clk);
    if (!src_ready[1]) r1_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a  = 5'(i * 8 + int'($urandom_range(0, 7)));
      dt = {4'(i), 28'(seq[i]), 32'($urandom)};
      seq[i]++;
      src_valid[i] = v[i];
      src_addr[i]  = a;
      src_data[i]  = dt;
      if (v[i] && src_ready[i]) begin
        acc[i]++;
        if (a != 5'd0) exp_q[i].push_back({a, dt});
      end
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    stream_cycle(4'b0000);
    while (pending() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 64'(pending()), 64'd0);
    @(negedge clk);
    chk({nm, "_idle"}, 64'(idle), 64'd1);
  endtask

  typedef struct {
    logic [3:0]       vld;
    logic [3:0][4:0]  addr;
    logic [3:0][63:0] data;
    logic [2:0]       we1;
    logic [2:0][4:0]  a1;
    logic [2:0][63:0] d1;
    logic [2:0]       we2;
    logic [2:0][4:0]  a2;
    logic [2:0][63:0] d2;
    logic             waw;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  task automatic cmp_out(input int n, input int c, input logic [2:0] ew,
                         input logic [2:0][4:0] ea, input logic [2:0][63:0] ed);
    logic [4:0]  a [3];
    logic [63:0] d [3];
    a[0] = waddr0; a[1] = waddr1; a[2] = waddr2;
    d[0] = wd0;    d[1] = wd1;    d[2] = wd2;
    chk($sformatf("v%0d_c%0d_we", n, c), 64'({we2, we1, we0}), 64'(ew));
    for (int k = 0; k < 3; k++)
      if (ew[k]) begin
        chk($sformatf("v%0d_c%0d_waddr%0d", n, c, k), 64'(a[k]), 64'(ea[k]));
        chk($sformatf("v%0d_c%0d_wd%0d", n, c, k), d[k], ed[k]);
      end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    for (int i = 0; i < 4; i++) begin acc[i] = 0; seq[i] = 0; end
    for (int i = 0; i < NV; i++) tbl[i] = '{default: '0};

    // single result
    tbl[0].vld = 4'b0001; tbl[0].addr[0] = 5; tbl[0].data[0] = 64'h1234;
    tbl[0].we1 = 3'b001;  tbl[0].a1[0] = 5;   tbl[0].d1[0] = 64'h1234;
    // r0 drop
    tbl[1].vld = 4'b0100; tbl[1].addr[2] = 0; tbl[1].data[2] = 64'hFFFF;
    // all four: src0..2 first, src3 next cycle on port 0
    tbl[2].vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tbl[2].addr[i] = 5'(i + 1);
      tbl[2].data[i] = 64'(32'h100 + i);
    end
    tbl[2].we1 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tbl[2].a1[k] = 5'(k + 1);
      tbl[2].d1[k] = 64'(32'h100 + k);
    end
    tbl[2].we2 = 3'b001; tbl[2].a2[0] = 4; tbl[2].d2[0] = 64'h103;
    // sparse sources packed onto ports 0,1
    tbl[3].vld = 4'b1010; tbl[3].addr[1] = 8; tbl[3].addr[3] = 9;
    tbl[3].data[1] = 64'h21; tbl[3].data[3] = 64'h23;
    tbl[3].we1 = 3'b011; tbl[3].a1[0] = 8; tbl[3].a1[1] = 9;
    tbl[3].d1[0] = 64'h21; tbl[3].d1[1] = 64'h23;
    // conflict src0/src1 on r7
    tbl[4].vld = 4'b0011; tbl[4].addr[0] = 7; tbl[4].addr[1] = 7;
    tbl[4].data[0] = 64'hA; tbl[4].data[1] = 64'hB;
    tbl[4].we1 = 3'b001; tbl[4].a1[0] = 7; tbl[4].d1[0] = 64'hA;
    tbl[4].we2 = 3'b001; tbl[4].a2[0] = 7; tbl[4].d2[0] = 64'hB;
    tbl[4].waw = 1'b1;
    // lone high source, top register
    tbl[5].vld = 4'b1000; tbl[5].addr[3] = 31; tbl[5].data[3] = 64'hDEADBEEF00000001;
    tbl[5].we1 = 3'b001; tbl[5].a1[0] = 31; tbl[5].d1[0] = 64'hDEADBEEF00000001;
    // conflict in the middle of the scan: src1 deferred, src2 still granted
    tbl[6].vld = 4'b0111; tbl[6].addr[0] = 7; tbl[6].addr[1] = 7; tbl[6].addr[2] = 9;
    tbl[6].data[0] = 64'h70; tbl[6].data[1] = 64'h71; tbl[6].data[2] = 64'h90;
    tbl[6].we1 = 3'b011; tbl[6].a1[0] = 7; tbl[6].a1[1] = 9;
    tbl[6].d1[0] = 64'h70; tbl[6].d1[1] = 64'h90;
    tbl[6].we2 = 3'b001; tbl[6].a2[0] = 7; tbl[6].d2[0] = 64'h71;
    tbl[6].waw = 1'b1;

    // reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", 64'({we2, we1, we0}), 64'd0);
    chk("rst_waddr", 64'({waddr2, waddr1, waddr0}), 64'd0);
    chk("rst_wd0", wd0, 64'd0);
    chk("rst_waw", 64'(waw_err), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(src_ready), 64'hF);

    // table: inject at cycle N, outputs at N+2 and N+3
    for (int n = 0; n < NV; n++) begin
      do_reset();
      @(negedge clk);
      src_valid = tbl[n].vld;
      src_addr  = tbl[n].addr;
      src_data  = tbl[n].data;
      @(negedge clk);
      src_valid = '0;
      chk($sformatf("v%0d_ready", n), 64'(src_ready), 64'hF);
      @(negedge clk);
      cmp_out(n, 1, tbl[n].we1, tbl[n].a1, tbl[n].d1);
      @(negedge clk);
      cmp_out(n, 2, tbl[n].we2, tbl[n].a2, tbl[n].d2);
      @(negedge clk);
      chk($sformatf("v%0d_waw", n), 64'(waw_err), 64'(tbl[n].waw));
      chk($sformatf("v%0d_idle", n), 64'(idle), 64'd1);
    end

    // single source sustains one result per cycle
    do_reset();
    sb_on = 1'b1;
    a0 = acc[0];
    repeat (10) stream_cycle(4'b0001);
    chk("sustain_src0", 64'(acc[0] - a0), 64'd10);
    drain("sustain");

    // backpressure: src1 valid for 6 cycles against saturated src0,2,3
    r1_low = 1'b0;
    for (int c = 0; c < 10; c++) stream_cycle({1'b1, 1'b1, (c < 6), 1'b1});
    chk("bp_src1_ready_dropped", 64'(r1_low), 64'd1);
    drain("bp");

    // random streaming
    repeat (200) stream_cycle(4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)));
    drain("rand");
    chk("stream_waw", 64'(waw_err), 64'd0);

    // reset in the middle of saturated traffic
    repeat (5) stream_cycle(4'b1111);
    @(negedge clk);
    sb_on = 1'b0;
    chk("mid_busy", 64'(idle), 64'd0);
    rst_n = 1'b0;
    src_valid = '0;
    #1;
    chk("mid_rst_we", 64'({we2, we1, we0}), 64'd0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 64'(src_ready), 64'hF);
    chk("mid_idle", 64'(idle), 64'd1);
    chk("mid_waw", 64'(waw_err), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_write", 64'({we2, we1, we0}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
